// File: rtl/muntjac_btb_update_ctrl.sv
// rtl/muntjac_btb_update_ctrl.sv - BTB write-port owner: training FIFO drain plus reset/flush invalidation sweeps.
package muntjac_btb_pkg;
  typedef enum logic [2:0] {
    BRANCH_NONE     = 3'b000,
    BRANCH_YIELD    = 3'b001,
    BRANCH_JUMP     = 3'b100,
    BRANCH_CALL     = 3'b101,
    BRANCH_RET      = 3'b110,
    BRANCH_RET_CALL = 3'b111
  } branch_type_e;
endpackage

module muntjac_btb_update_ctrl
  import muntjac_btb_pkg::*;
#(
  parameter  int AddrLen    = 64,
  parameter  int IndexWidth = 8,
  parameter  int QueueDepth = 4,
  localparam int TagWidth   = AddrLen - IndexWidth - 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  branch_type_e          req0_branch_type_i,
  input  logic [AddrLen-1:0]    req0_pc_i,
  input  logic                  req0_partial_i,
  input  logic [AddrLen-1:0]    req0_npc_i,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  branch_type_e          req1_branch_type_i,
  input  logic [AddrLen-1:0]    req1_pc_i,
  input  logic                  req1_partial_i,
  input  logic [AddrLen-1:0]    req1_npc_i,
  input  logic                  flush_req_i,
  output logic                  flush_busy_o,
  output logic                  lookup_inhibit_o,
  output logic                  btb_w_valid_o,
  output logic                  btb_w_clear_o,
  output logic [IndexWidth-1:0] btb_w_index_o,
  output logic [TagWidth-1:0]   btb_w_tag_o,
  output branch_type_e          btb_w_branch_type_o,
  output logic                  btb_w_partial_o,
  output logic [AddrLen-2:0]    btb_w_target_o
);

  localparam int PtrW = $clog2(QueueDepth);
  localparam logic [PtrW:0] DepthC = (PtrW+1)'(QueueDepth);
  localparam logic [IndexWidth-1:0] LastIdx = {IndexWidth{1'b1}};

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FLUSH} state_e;

  // Only pc[AddrLen-1:2] and npc[AddrLen-1:1] ever reach the BTB.
  typedef struct packed {
    branch_type_e          branch_type;
    logic                  partial;
    logic [AddrLen-3:0]    pc_hi;
    logic [AddrLen-2:0]    target;
  } entry_t;

  state_e                state_q, state_d;
  logic [IndexWidth-1:0] sweep_cnt_q, sweep_cnt_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]         count_q, count_d;
  entry_t                mem_q [QueueDepth];

  logic          sweeping, acc0, acc1, pop;
  logic [PtrW:0] free;
  entry_t        entry0, entry1, head;

  logic unused_bits;
  assign unused_bits = ^{req0_pc_i[1:0], req1_pc_i[1:0], req0_npc_i[0], req1_npc_i[0]};

  assign entry0   = '{req0_branch_type_i, req0_partial_i, req0_pc_i[AddrLen-1:2], req0_npc_i[AddrLen-1:1]};
  assign entry1   = '{req1_branch_type_i, req1_partial_i, req1_pc_i[AddrLen-1:2], req1_npc_i[AddrLen-1:1]};
  assign head     = mem_q[rd_ptr_q];
  assign sweeping = (state_q != ST_RUN);
  assign free     = DepthC - count_q;

  // Space is judged from the registered count only; a same-cycle pop does not count.
  assign req0_ready_o = !rst_i && !sweeping && !flush_req_i && (free != '0);
  assign req1_ready_o = !rst_i && !sweeping && !flush_req_i &&
                        ((free >= (PtrW+1)'(2)) || ((free != '0) && !req0_valid_i));

  assign acc0 = req0_valid_i && req0_ready_o;
  assign acc1 = req1_valid_i && req1_ready_o;
  assign pop  = !sweeping && (count_q != '0);

  always_comb begin
    flush_busy_o        = rst_i || sweeping;
    lookup_inhibit_o    = rst_i || sweeping;
    btb_w_valid_o       = 1'b0;
    btb_w_clear_o       = 1'b0;
    btb_w_index_o       = '0;
    btb_w_tag_o         = '0;
    btb_w_branch_type_o = BRANCH_NONE;
    btb_w_partial_o     = 1'b0;
    btb_w_target_o      = '0;
    if (sweeping) begin
      btb_w_valid_o = !rst_i;
      btb_w_clear_o = 1'b1;
      btb_w_index_o = sweep_cnt_q;
    end else if (pop) begin
      btb_w_valid_o       = !rst_i;
      btb_w_index_o       = head.pc_hi[IndexWidth-1:0];
      btb_w_tag_o         = head.pc_hi[AddrLen-3:IndexWidth];
      btb_w_branch_type_o = head.branch_type;
      btb_w_partial_o     = head.partial;
      btb_w_target_o      = head.target;
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    case (state_q)
      ST_INIT, ST_FLUSH: begin
        sweep_cnt_d = sweep_cnt_q + IndexWidth'(1);
        if (sweep_cnt_q == LastIdx) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (flush_req_i) begin
          // The head still writes this cycle; everything queued is dropped.
          state_d     = ST_FLUSH;
          sweep_cnt_d = '0;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          count_d     = '0;
        end else begin
          wr_ptr_d = wr_ptr_q + PtrW'(acc0) + PtrW'(acc1);
          rd_ptr_d = rd_ptr_q + PtrW'(pop);
          count_d  = count_q + (PtrW+1)'(acc0) + (PtrW+1)'(acc1) - (PtrW+1)'(pop);
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_INIT;
      sweep_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (acc0) mem_q[wr_ptr_q] <= entry0;
    if (acc1) mem_q[wr_ptr_q + PtrW'(acc0)] <= entry1;
  end

endmodule

// File: tb/tb_muntjac_btb_update_ctrl.sv
// tb/tb_muntjac_btb_update_ctrl.sv - randomized bench for muntjac_btb_update_ctrl against a queue-based model.
module tb_muntjac_btb_update_ctrl;
  import muntjac_btb_pkg::*;

  localparam int AW   = 64;
  localparam int IW   = 3;
  localparam int QD   = 4;
  localparam int TW   = AW - IW - 2;
  localparam int NENT = 1 << IW;
  localparam int NCYC = 4000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v0 = 1'b0, v1 = 1'b0, flush = 1'b0;
  logic r0, r1, busy, inhibit;
  branch_type_e bt0 = BRANCH_NONE, bt1 = BRANCH_NONE, w_bt;
  logic [AW-1:0] pc0 = '0, pc1 = '0, npc0 = '0, npc1 = '0;
  logic p0 = 1'b0, p1 = 1'b0;
  logic w_valid, w_clear, w_partial;
  logic [IW-1:0] w_index;
  logic [TW-1:0] w_tag;
  logic [AW-2:0] w_target;

  muntjac_btb_update_ctrl #(.AddrLen(AW), .IndexWidth(IW), .QueueDepth(QD)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v0), .req0_ready_o(r0), .req0_branch_type_i(bt0),
    .req0_pc_i(pc0), .req0_partial_i(p0), .req0_npc_i(npc0),
    .req1_valid_i(v1), .req1_ready_o(r1), .req1_branch_type_i(bt1),
    .req1_pc_i(pc1), .req1_partial_i(p1), .req1_npc_i(npc1),
    .flush_req_i(flush), .flush_busy_o(busy), .lookup_inhibit_o(inhibit),
    .btb_w_valid_o(w_valid), .btb_w_clear_o(w_clear), .btb_w_index_o(w_index),
    .btb_w_tag_o(w_tag), .btb_w_branch_type_o(w_bt), .btb_w_partial_o(w_partial),
    .btb_w_target_o(w_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic [AW-1:0] npc;
    branch_type_e  bt;
    logic          partial;
  } req_t;

  req_t mq[$];
  bit   m_sweep = 1'b1;
  int   m_pos = 0;
  int   total = 0;
  int   bad = 0;

  branch_type_e bt_tab [6] = '{BRANCH_NONE, BRANCH_YIELD, BRANCH_JUMP,
                               BRANCH_CALL, BRANCH_RET, BRANCH_RET_CALL};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] rand_pc();
    logic [AW-1:0] x;
    x = {$urandom, $urandom};
    if ($urandom_range(0, 1) == 0) x = AW'($urandom_range(0, 255)) << 2;
    return x;
  endfunction

  initial begin
    int  pct_valid;
    bit  e_r0, e_r1, e_valid, e_clear, e_part;
    int  free;
    logic [IW-1:0] e_idx;
    logic [TW-1:0] e_tag;
    logic [AW-2:0] e_tgt;
    branch_type_e  e_bt;
    req_t          a, b;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      rst = (cyc < 3) || ($urandom_range(0, 399) == 0);
      case ((cyc / 250) % 3)
        0:       pct_valid = 90;
        1:       pct_valid = 25;
        default: pct_valid = 60;
      endcase
      v0    = ($urandom_range(0, 99) < pct_valid);
      v1    = ($urandom_range(0, 99) < pct_valid);
      flush = ($urandom_range(0, 39) == 0);
      pc0   = rand_pc();
      pc1   = rand_pc();
      npc0  = {$urandom, $urandom};
      npc1  = {$urandom, $urandom};
      bt0   = bt_tab[$urandom_range(0, 5)];
      bt1   = bt_tab[$urandom_range(0, 5)];
      p0    = 1'($urandom);
      p1    = 1'($urandom);
      #3;

      e_r0 = 0; e_r1 = 0; e_valid = 0; e_clear = 0; e_part = 0;
      e_idx = '0; e_tag = '0; e_tgt = '0; e_bt = BRANCH_NONE;
      if (!rst && m_sweep) begin
        e_valid = 1; e_clear = 1; e_idx = IW'(m_pos);
      end else if (!rst) begin
        free = QD - mq.size();
        e_r0 = !flush && (free >= 1);
        e_r1 = !flush && ((free >= 2) || (free >= 1 && !v0));
        if (mq.size() > 0) begin
          e_valid = 1;
          e_idx   = mq[0].pc[2 +: IW];
          e_tag   = mq[0].pc[AW-1:2+IW];
          e_tgt   = mq[0].npc[AW-1:1];
          e_bt    = mq[0].bt;
          e_part  = mq[0].partial;
        end
      end

      check_eq("req0_ready", 64'(r0), 64'(e_r0));
      check_eq("req1_ready", 64'(r1), 64'(e_r1));
      check_eq("flush_busy", 64'(busy), 64'(rst || m_sweep));
      check_eq("lookup_inhibit", 64'(inhibit), 64'(rst || m_sweep));
      check_eq("w_valid", 64'(w_valid), 64'(e_valid));
      if (e_valid) begin
        check_eq("w_clear", 64'(w_clear), 64'(e_clear));
        check_eq("w_index", 64'(w_index), 64'(e_idx));
        check_eq("w_tag", 64'(w_tag), 64'(e_tag));
        check_eq("w_type", 64'(w_bt), 64'(e_bt));
        check_eq("w_partial", 64'(w_partial), 64'(e_part));
        check_eq("w_target", 64'(w_target), 64'(e_tgt));
      end

      if (rst) begin
        m_sweep = 1; m_pos = 0; mq.delete();
      end else if (m_sweep) begin
        m_pos++;
        if (m_pos == NENT) begin
          m_sweep = 0; m_pos = 0;
        end
      end else if (flush) begin
        mq.delete(); m_sweep = 1; m_pos = 0;
      end else begin
        if (mq.size() > 0) void'(mq.pop_front());
        a = '{pc0, npc0, bt0, p0};
        b = '{pc1, npc1, bt1, p1};
        if (v0 && e_r0) mq.push_back(a);
        if (v1 && e_r1) mq.push_back(b);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
